// File: rtl/fpu_vector_tester_if.sv
// ROM and FPU-under-test bus as seen by the tester.
// master = tester side, slave = board/testbench side (ROM plus FPU IP).
interface fpu_vector_tester_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] vec_addr;
   logic [WIDTH-1:0]  vec_src1;
   logic [WIDTH-1:0]  vec_src2;
   logic [WIDTH-1:0]  vec_exp;
   logic [WIDTH-1:0]  dut_src1;
   logic [WIDTH-1:0]  dut_src2;
   logic [WIDTH-1:0]  dut_res;

   modport master (
      output vec_addr, dut_src1, dut_src2,
      input  vec_src1, vec_src2, vec_exp, dut_res
   );

   modport slave (
      input  vec_addr, dut_src1, dut_src2,
      output vec_src1, vec_src2, vec_exp, dut_res
   );
endinterface

// File: rtl/fpu_vector_tester.sv
// Streams ROM vectors into a pipelined FPU, checks results LATENCY cycles later, and shows
// pass/fail counters and the first failing index/result on six 7-seg digits.
module fpu_vector_tester #(
   parameter int WIDTH    = 32,
   parameter int NUM_VEC  = 16,
   parameter int ADDR_W   = 4,
   parameter int LATENCY  = 7,
   parameter int MASK_LSB = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic [1:0]           disp_sel_i,
   fpu_vector_tester_if.master  bus,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 pass_o,
   output logic [6:0]           segment7_1_o,
   output logic [6:0]           segment7_2_o,
   output logic [6:0]           segment7_3_o,
   output logic [6:0]           segment7_4_o,
   output logic [6:0]           segment7_5_o,
   output logic [6:0]           segment7_6_o
);
   localparam int CW = ADDR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic              vld;
      logic [WIDTH-1:0]  exp;
      logic [ADDR_W-1:0] addr;
   } tag_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     issue_cnt_q, issue_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]  src1_q, src1_d, src2_q, src2_d;
   logic [CW-1:0]     pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
   logic [ADDR_W-1:0] first_idx_q, first_idx_d;
   logic [WIDTH-1:0]  first_res_q, first_res_d;
   tag_t              dl_q [LATENCY];
   tag_t              push, tap;
   logic              match;

   assign tap   = dl_q[LATENCY-1];
   assign match = (bus.dut_res[WIDTH-1:MASK_LSB] == tap.exp[WIDTH-1:MASK_LSB]);

   always_comb begin
      push.vld  = (state_q == S_ISSUE);
      push.exp  = bus.vec_exp;
      push.addr = bus.vec_addr;
   end

   always_comb begin
      state_d     = state_q;
      issue_cnt_d = issue_cnt_q;
      addr_d      = addr_q;
      src1_d      = '0;
      src2_d      = '0;
      pass_cnt_d  = pass_cnt_q;
      fail_cnt_d  = fail_cnt_q;
      first_idx_d = first_idx_q;
      first_res_d = first_res_q;

      if (tap.vld) begin
         if (match) begin
            pass_cnt_d = pass_cnt_q + CW'(1);
         end else begin
            fail_cnt_d = fail_cnt_q + CW'(1);
            // Only the first mismatch of a run is latched for display.
            if (fail_cnt_q == '0) begin
               first_idx_d = tap.addr;
               first_res_d = bus.dut_res;
            end
         end
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d     = S_ISSUE;
               issue_cnt_d = '0;
               addr_d      = '0;
               pass_cnt_d  = '0;
               fail_cnt_d  = '0;
               first_idx_d = '0;
               first_res_d = '0;
            end
         end
         S_ISSUE: begin
            src1_d      = bus.vec_src1;
            src2_d      = bus.vec_src2;
            issue_cnt_d = issue_cnt_q + CW'(1);
            if (issue_cnt_q == CW'(NUM_VEC - 1)) begin
               addr_d  = '0;
               state_d = S_DRAIN;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
            end
         end
         S_DRAIN: begin
            if (pass_cnt_q + fail_cnt_q == CW'(NUM_VEC)) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         issue_cnt_q <= '0;
         addr_q      <= '0;
         src1_q      <= '0;
         src2_q      <= '0;
         pass_cnt_q  <= '0;
         fail_cnt_q  <= '0;
         first_idx_q <= '0;
         first_res_q <= '0;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         addr_q      <= addr_d;
         src1_q      <= src1_d;
         src2_q      <= src2_d;
         pass_cnt_q  <= pass_cnt_d;
         fail_cnt_q  <= fail_cnt_d;
         first_idx_q <= first_idx_d;
         first_res_q <= first_res_d;
      end
   end

   // Expected-result delay line; reset flushes every valid bit so no stale check survives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LATENCY; i++) dl_q[i] <= '0;
      end else begin
         dl_q[0] <= push;
         for (int i = 1; i < LATENCY; i++) dl_q[i] <= dl_q[i-1];
      end
   end

   assign bus.vec_addr = addr_q;
   assign bus.dut_src1 = src1_q;
   assign bus.dut_src2 = src2_q;
   assign busy_o       = (state_q == S_ISSUE) || (state_q == S_DRAIN);
   assign done_o       = (state_q == S_DONE);
   assign pass_o       = (state_q == S_DONE) && (fail_cnt_q == '0);

   // Segment order {g,f,e,d,c,b,a}, active high.
   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
         4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
         4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
         4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
      endcase
   endfunction

   logic [19:0] page;
   always_comb begin
      page = '0;
      case (disp_sel_i)
         2'd0:    page = {8'(pass_cnt_q), 8'(fail_cnt_q), 4'(first_idx_q)};
         2'd1:    page = first_res_q[19:0];
         2'd2:    page = bus.dut_res[19:0];
         default: page = {first_res_q[31:24], first_res_q[11:0]};
      endcase
   end

   assign segment7_1_o = seg7({2'b00, state_q});
   assign segment7_2_o = seg7(page[19:16]);
   assign segment7_3_o = seg7(page[15:12]);
   assign segment7_4_o = seg7(page[11:8]);
   assign segment7_5_o = seg7(page[7:4]);
   assign segment7_6_o = seg7(page[3:0]);
endmodule

// File: tb/tb_fpu_vector_tester.sv
// Bench: random vector ROM, a toy pipelined "FPU" (integer add) with selectable delay and
// fault injection, and a run-level reference model for counts, first index and first result.
module tb_fpu_vector_tester;
   localparam int W = 32, N = 16, AW = 4, LAT = 7;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] disp_sel = 2'd0;
   logic       busy0, done0, pass0, busy1, done1, pass1;
   logic [6:0] sg0 [6];
   logic [6:0] sg1 [6];

   always #5 clk = ~clk;

   fpu_vector_tester_if #(.WIDTH(W), .ADDR_W(AW)) bus0 ();
   fpu_vector_tester_if #(.WIDTH(W), .ADDR_W(AW)) bus1 ();

   fpu_vector_tester #(.WIDTH(W), .NUM_VEC(N), .ADDR_W(AW), .LATENCY(LAT), .MASK_LSB(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .disp_sel_i(disp_sel), .bus(bus0.master),
      .busy_o(busy0), .done_o(done0), .pass_o(pass0),
      .segment7_1_o(sg0[0]), .segment7_2_o(sg0[1]), .segment7_3_o(sg0[2]),
      .segment7_4_o(sg0[3]), .segment7_5_o(sg0[4]), .segment7_6_o(sg0[5]));

   fpu_vector_tester #(.WIDTH(W), .NUM_VEC(N), .ADDR_W(AW), .LATENCY(LAT), .MASK_LSB(1)) u_dut_m (
      .clk(clk), .rst_n(rst_n), .start_i(start), .disp_sel_i(disp_sel), .bus(bus1.master),
      .busy_o(busy1), .done_o(done1), .pass_o(pass1),
      .segment7_1_o(sg1[0]), .segment7_2_o(sg1[1]), .segment7_3_o(sg1[2]),
      .segment7_4_o(sg1[3]), .segment7_5_o(sg1[4]), .segment7_6_o(sg1[5]));

   logic [W-1:0] rom1 [N], rom2 [N], romx [N];
   logic [W-1:0] pipe0 [8], pipe1 [8];
   int           dly = LAT;
   bit           cen = 1'b0;
   int           cidx = 5;
   int           nvec = 0, nmiss = 0;

   assign bus0.vec_src1 = rom1[bus0.vec_addr];
   assign bus0.vec_src2 = rom2[bus0.vec_addr];
   assign bus0.vec_exp  = romx[bus0.vec_addr];
   assign bus1.vec_src1 = rom1[bus1.vec_addr];
   assign bus1.vec_src2 = rom2[bus1.vec_addr];
   assign bus1.vec_exp  = romx[bus1.vec_addr];
   assign bus0.dut_res  = pipe0[dly-2];
   assign bus1.dut_res  = pipe1[dly-2];

   function automatic logic [W-1:0] fpu_op(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      r = a + b;
      if (cen && a == rom1[cidx] && b == rom2[cidx]) r = r ^ 32'h1;
      return r;
   endfunction

   always @(posedge clk) begin
      pipe0[0] <= fpu_op(bus0.dut_src1, bus0.dut_src2);
      pipe1[0] <= fpu_op(bus1.dut_src1, bus1.dut_src2);
      for (int i = 1; i < 8; i++) begin
         pipe0[i] <= pipe0[i-1];
         pipe1[i] <= pipe1[i-1];
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nmiss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] enc(input logic [3:0] n);
      logic [6:0] t [16];
      t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return t[n];
   endfunction

   function automatic logic [34:0] seg5(input logic [19:0] v);
      return {enc(v[19:16]), enc(v[15:12]), enc(v[11:8]), enc(v[7:4]), enc(v[3:0])};
   endfunction

   function automatic logic [34:0] page0();
      return {sg0[1], sg0[2], sg0[3], sg0[4], sg0[5]};
   endfunction

   // Run-level model: check i sees the result of vector i-(d-LAT); before vector 0 the IP saw zeros.
   task automatic ref_run(input int d, input bit ce, input int mask,
                          output int pc, output int fc, output int fi, output logic [W-1:0] fr);
      logic [W-1:0] obs;
      int j;
      pc = 0; fc = 0; fi = 0; fr = '0;
      for (int i = 0; i < N; i++) begin
         j = i - (d - LAT);
         obs = (j < 0) ? '0 : rom1[j] + rom2[j];
         if (ce && j == cidx) obs = obs ^ 32'h1;
         if ((obs >> mask) == (romx[i] >> mask)) pc++;
         else begin
            if (fc == 0) begin fi = i; fr = obs; end
            fc++;
         end
      end
   endtask

   task automatic do_run(input int d, input bit ce, input bit poke);
      int errs = 0, cyc = 0;
      dly = d; cen = ce;
      @(negedge clk) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("busy_after_start", busy0, 1);
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         if (k <= N && (bus0.dut_src1 !== rom1[k-1] || bus0.dut_src2 !== rom2[k-1]
                        || bus0.vec_addr !== AW'(k % N))) errs++;
         if (poke) start = (k == 5);
         if (done0) begin cyc = k; break; end
      end
      start = 1'b0;
      chk("issue_seq", errs, 0);
      chk("run_cycles", cyc, N + LAT + 1);
   endtask

   task automatic check_results(input string nm, input int d, input bit ce);
      int pc, fc, fi;
      logic [W-1:0] fr;
      ref_run(d, ce, 0, pc, fc, fi, fr);
      @(negedge clk);
      chk({nm, ".done"}, {busy0, done0}, 2'b01);
      chk({nm, ".pass"}, pass0, fc == 0);
      chk({nm, ".state_dig"}, sg0[0], enc(4'd3));
      disp_sel = 2'd0; #1 chk({nm, ".page0"}, page0(), seg5({8'(pc), 8'(fc), 4'(fi)}));
      disp_sel = 2'd1; #1 chk({nm, ".page1"}, page0(), seg5(fr[19:0]));
      disp_sel = 2'd3; #1 chk({nm, ".page3"}, page0(), seg5({fr[31:24], fr[11:0]}));
      disp_sel = 2'd2; #1 chk({nm, ".page2"}, page0(), seg5(bus0.dut_res[19:0]));
      disp_sel = 2'd0;
      ref_run(d, ce, 1, pc, fc, fi, fr);
      chk({nm, ".pass_mask1"}, {done1, pass1}, {1'b1, fc == 0});
   endtask

   initial begin
      logic [31:0] r;
      bit found;
      for (int i = 0; i < N; i++) begin
         r = $urandom();
         rom1[i] = {r[31:4], 4'(i)} | 32'h100;
         rom2[i] = $urandom();
         romx[i] = rom1[i] + rom2[i];
      end

      repeat (3) @(posedge clk);
      #1;
      chk("rst.flags", {busy0, done0, pass0}, 3'b000);
      chk("rst.vec_addr", bus0.vec_addr, 0);
      chk("rst.dut_src", {bus0.dut_src1, bus0.dut_src2}, 64'h0);
      chk("rst.state_dig", sg0[0], enc(4'd0));
      chk("rst.page0", page0(), seg5(20'h0));
      @(negedge clk) rst_n = 1'b1;
      repeat (10) @(posedge clk);

      do_run(LAT, 1'b0, 1'b0);     check_results("clean", LAT, 1'b0);
      do_run(LAT, 1'b1, 1'b0);     check_results("inject", LAT, 1'b1);
      do_run(LAT + 1, 1'b0, 1'b0); check_results("latency", LAT + 1, 1'b0);
      do_run(LAT, 1'b0, 1'b1);     check_results("ignore", LAT, 1'b0);
      do_run(LAT, 1'b0, 1'b0);     check_results("rerun", LAT, 1'b0);

      // Mid-run reset at vector 9.
      @(negedge clk) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #1;
         if (bus0.vec_addr == AW'(9)) begin found = 1'b1; break; end
      end
      chk("reach_vec9", found, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst.flags", {busy0, done0, pass0}, 3'b000);
      chk("midrst.state_dig", sg0[0], enc(4'd0));
      chk("midrst.bus", {bus0.vec_addr, bus0.dut_src1}, 36'h0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("midrst.idle_page0", page0(), seg5(20'h0));
      chk("midrst.idle_busy", busy0, 0);
      do_run(LAT, 1'b0, 1'b0);     check_results("postrst", LAT, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
      $finish;
   end
endmodule
